// File: rtl/otfs_frame_loader_if.sv
// otfs_frame_loader_if: sample-stream input and parallel-frame output bundle of the OTFS frame loader.
interface otfs_frame_loader_if #(
  parameter int unsigned FRAME_LEN = 64,
  parameter int unsigned DW        = 12
);
  logic                    s_valid;
  logic                    s_ready;
  logic [DW-1:0]           s_re;
  logic [DW-1:0]           s_im;
  logic                    s_last;
  logic [FRAME_LEN*DW-1:0] frame_r;
  logic [FRAME_LEN*DW-1:0] frame_i;
  logic                    frame_valid;
  logic                    frame_ack;
  logic                    err;
  logic [7:0]              err_cnt;

  // master: sample source and frame consumer; slave: the loader
  modport master (
    output s_valid, s_re, s_im, s_last, frame_ack,
    input  s_ready, frame_r, frame_i, frame_valid, err, err_cnt
  );

  modport slave (
    input  s_valid, s_re, s_im, s_last, frame_ack,
    output s_ready, frame_r, frame_i, frame_valid, err, err_cnt
  );
endinterface

// File: rtl/otfs_frame_loader.sv
// otfs_frame_loader: ping-pong buffer collecting FRAME_LEN complex samples into a parallel ISFFT frame.
// Optional s_last framing check is enabled by defining FRAME_LAST_CHECK_EN.
module otfs_frame_loader #(
  parameter int unsigned FRAME_LEN = 64,
  parameter int unsigned DW        = 12
) (
  input  logic               clk,
  input  logic               rst,
  otfs_frame_loader_if.slave bus
);
  localparam int unsigned   IW       = $clog2(FRAME_LEN);
  localparam int unsigned   FW       = FRAME_LEN * DW;
  localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_LEN - 1);

  typedef enum logic {FREE = 1'b0, FULL = 1'b1} bank_st_e;

  bank_st_e        st_q [2];
  bank_st_e        st_d [2];
  logic [FW-1:0]   mem_r [2];
  logic [FW-1:0]   mem_i [2];
  logic [IW-1:0]   idx_q, idx_d;
  logic            wbank_q, wbank_d;
  logic            rbank_q, rbank_d;
  logic            fv_q, fv_d;
  logic            err_q, err_d;
  logic [7:0]      err_cnt_q, err_cnt_d;
  logic            accept, at_last, frame_err, complete, ack;
  int unsigned     slot_lo;

  assign accept  = bus.s_valid & bus.s_ready;
  assign at_last = (idx_q == LAST_IDX);
  assign ack     = fv_q & bus.frame_ack;
  assign slot_lo = 32'(idx_q) * DW;

`ifdef FRAME_LAST_CHECK_EN
  // s_last must coincide exactly with the final slot of a frame
  assign frame_err = accept & (bus.s_last ^ at_last);
`else
  logic unused_last;
  assign unused_last = bus.s_last;
  assign frame_err   = 1'b0;
`endif

  assign complete = accept & at_last & ~frame_err;

  // Write-side and read-side bank updates are independent; they never touch the same bank.
  always_comb begin
    st_d      = st_q;
    idx_d     = idx_q;
    wbank_d   = wbank_q;
    rbank_d   = rbank_q;
    err_d     = frame_err;
    err_cnt_d = err_cnt_q;
    if (accept) begin
      idx_d = (at_last | frame_err) ? '0 : idx_q + IW'(1);
    end
    if (complete) begin
      st_d[wbank_q] = FULL;
      wbank_d       = ~wbank_q;
    end
    if (ack) begin
      st_d[rbank_q] = FREE;
      rbank_d       = ~rbank_q;
    end
    if (frame_err && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
    fv_d = (st_d[rbank_d] == FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q[0]   <= FREE;
      st_q[1]   <= FREE;
      mem_r[0]  <= '0;
      mem_r[1]  <= '0;
      mem_i[0]  <= '0;
      mem_i[1]  <= '0;
      idx_q     <= '0;
      wbank_q   <= 1'b0;
      rbank_q   <= 1'b0;
      fv_q      <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      st_q[0]   <= st_d[0];
      st_q[1]   <= st_d[1];
      idx_q     <= idx_d;
      wbank_q   <= wbank_d;
      rbank_q   <= rbank_d;
      fv_q      <= fv_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      // a rejected partial frame may leave stale slots; they are overwritten before the bank fills
      if (accept) begin
        mem_r[wbank_q][slot_lo +: DW] <= bus.s_re;
        mem_i[wbank_q][slot_lo +: DW] <= bus.s_im;
      end
    end
  end

  assign bus.s_ready     = (st_q[wbank_q] == FREE) & ~rst;
  assign bus.frame_valid = fv_q;
  assign bus.frame_r     = mem_r[rbank_q];
  assign bus.frame_i     = mem_i[rbank_q];
  assign bus.err         = err_q;
  assign bus.err_cnt     = err_cnt_q;

endmodule

// File: doc/otfs_frame_loader.md
OTFS_FRAME_LOADER -- requirements
Module: otfs_frame_loader

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 64, fixed at 64: number of complex samples per delay-Doppler frame (8x8 grid).
REQ-002 SHALL have parameter DW, default 12: bit width of each real or imaginary sample component.
REQ-003 SHALL provide `clk`, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL provide `rst`, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL provide `s_valid`, input, 1 bit: an input sample is present.
REQ-006 SHALL provide `s_ready`, output, 1 bit: the loader can accept a sample.
REQ-007 SHALL provide `s_re` and `s_im`, input, DW bits each: two's-complement sample, real and imaginary.
REQ-008 SHALL provide `s_last`, input, 1 bit: the sample marks the end of a frame.
REQ-009 SHALL provide `frame_r` and `frame_i`, output, FRAME_LEN*DW bits each: slot k occupies bits [k*DW +: DW] and drives ISFFT input in{k}.
REQ-010 SHALL provide `frame_valid`, output, 1 bit: a complete frame is presented on `frame_r`/`frame_i`.
REQ-011 SHALL provide `frame_ack`, input, 1 bit: the consumer has taken the presented frame.
REQ-012 SHALL provide `err`, output, 1 bit: one-cycle pulse on a framing error.
REQ-013 SHALL provide `err_cnt`, output, 8 bits: saturating count of framing errors.

Function
REQ-014 SHALL accept a sample on a rising edge only when `s_valid` and `s_ready` are both 1.
REQ-015 SHALL write the accepted sample into slot `idx` of the write bank, then increment `idx` modulo 64.
REQ-016 SHALL hold two banks (ping-pong), each with a FREE or FULL state, plus pointers `wbank` and `rbank`.
REQ-017 SHALL drive `s_ready` = 1 exactly when bank[`wbank`] is FREE and `rst` = 0; this is registered state only, with no combinational path from `s_valid` or `frame_ack`.
REQ-018 SHALL, on accepting the sample at `idx` = 63, mark bank[`wbank`] FULL, toggle `wbank`, and clear `idx` to 0.
REQ-019 SHALL drive `frame_valid` = 1 exactly when bank[`rbank`] is FULL; it rises the cycle after the slot-63 sample is accepted.
REQ-020 SHALL drive `frame_r`/`frame_i` from bank[`rbank`] and hold them stable while `frame_valid` = 1.
REQ-021 SHALL, on `frame_valid` and `frame_ack` both 1, mark bank[`rbank`] FREE and toggle `rbank`.
REQ-022 SHALL ignore `frame_ack` while `frame_valid` = 0.
REQ-023 SHALL, when a frame completes and an acknowledge occurs in the same cycle, apply both updates independently; no frame is lost or duplicated.
REQ-024 SHALL deassert `s_ready` when both banks are FULL and reassert it the cycle after the next acknowledge.
REQ-025 SHALL sustain back-to-back frames at one sample per cycle when `frame_ack` is returned within 64 cycles of `frame_valid` rising.
REQ-026 SHALL pass sample data unmodified: no scaling, no rounding.
REQ-027 SHALL present frames in arrival order.

Reset
REQ-028 SHALL, while `rst` = 1 at a clock edge, set `idx` = 0, both banks FREE and their contents 0, `wbank` = `rbank` = 0, `frame_valid` = 0, `s_ready` = 0, `err` = 0 and `err_cnt` = 0.
REQ-029 SHALL drive `s_ready` = 1 on the first cycle after `rst` deasserts.
REQ-030 SHALL, on reset asserted mid-frame or while a frame is presented, discard all buffered data; no `err` is raised.

Configuration
REQ-031 SHALL, with macro FRAME_LAST_CHECK_EN defined, pulse `err` for one cycle and increment `err_cnt` (saturating at 255) when `s_last` = 1 at `idx` != 63 or `s_last` = 0 at `idx` = 63.
REQ-032 SHALL, on such an error, discard the partial frame: `idx` = 0, the bank stays FREE, and `frame_valid` is unaffected.
REQ-033 SHALL, with FRAME_LAST_CHECK_EN undefined, ignore `s_last` and tie `err` = 0 and `err_cnt` = 0; frames are delimited by count only.

Verification
REQ-034 SHALL cover: reset, then 64 samples with re = k, im = -k and `s_last` on k = 63 -> `frame_valid` rises the next cycle, slot 5 = (5, 0xFFB), slot 63 = (63, 0xFC1).
REQ-035 SHALL cover: 192 samples with `frame_ack` held 0 -> `s_ready` drops after sample 127, 128 samples held, and after one ack the frame with samples 64..127 appears.
REQ-036 SHALL cover: `frame_ack` pulsed in the same cycle that slot 63 of the next frame is accepted -> `frame_valid` stays 1 and the second frame appears with no gap.
REQ-037 SHALL cover, with FRAME_LAST_CHECK_EN defined: `s_last` on sample 10 -> `err` pulses once, `err_cnt` = 1, no `frame_valid`, and the next 64 samples form a correct frame.
REQ-038 SHALL cover: `rst` asserted after 30 samples -> all outputs at reset values, and a following full frame is correct starting at slot 0.
REQ-039 SHALL cover: random `s_valid` and `frame_ack` over 1000 frames -> output frames match a reference model and `err_cnt` = 0.
